// File: rtl/bit_reverse_rx.sv
// Assembles WIDTH ASCII '0'/'1' characters (first character = bit 0) into a word,
// then presents it both as received and bit-reversed, with a ready/valid handshake on each side.
module bit_reverse_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char_in,
    input  logic             char_valid,
    output logic             char_ready,
    output logic [3:0]       addr,
    output logic [WIDTH-1:0] word_out,
    output logic [WIDTH-1:0] word_raw,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             err,
    output logic [7:0]       err_count,
    output logic [7:0]       word_count
);

    typedef enum logic {
        COLLECT,
        OUTPUT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] full_word;
    logic [WIDTH-1:0] reversed_word;
    logic             accept;
    logic             legal;
    logic             last_char;
    logic             deliver;

    assign char_ready = (state == COLLECT);
    assign accept     = char_valid && char_ready;
    assign legal      = (char_in == 8'h30) || (char_in == 8'h31);
    assign last_char  = (addr == 4'(WIDTH - 1));
    assign deliver    = (state == OUTPUT) && word_ready;

    // Partial word with the incoming bit merged in, so the final character lands in the delivered word.
    always_comb begin
        full_word     = shift_reg;
        reversed_word = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (addr == 4'(k)) begin
                full_word[k] = char_in[0];
            end
        end
        for (int k = 0; k < WIDTH; k++) begin
            reversed_word[WIDTH-1-k] = full_word[k];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: begin
                if (accept && legal && last_char) begin
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                if (word_ready) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr       <= '0;
            shift_reg  <= '0;
            word_out   <= '0;
            word_raw   <= '0;
            word_valid <= 1'b0;
            err        <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
        end else begin
            err <= 1'b0;
            if (accept) begin
                if (!legal) begin
                    err       <= 1'b1;
                    shift_reg <= '0;
                    addr      <= '0;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end else if (last_char) begin
                    word_raw   <= full_word;
                    word_out   <= reversed_word;
                    word_valid <= 1'b1;
                    shift_reg  <= '0;
                    addr       <= '0;
                end else begin
                    shift_reg <= full_word;
                    addr      <= addr + 4'd1;
                end
            end
            // Accept and deliver are mutually exclusive because char_ready is low in OUTPUT.
            if (deliver) begin
                word_valid <= 1'b0;
                word_count <= word_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bit_reverse_rx.sv
// Self-checking bench for bit_reverse_rx: directed scenarios plus a randomized run,
// all compared against a queue-based model of the character stream.
module tb_bit_reverse_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   char_in = 8'h00;
    logic         char_valid = 1'b0;
    logic         word_ready = 1'b0;
    logic         char_ready;
    logic [3:0]   addr;
    logic [W-1:0] word_out;
    logic [W-1:0] word_raw;
    logic         word_valid;
    logic         err;
    logic [7:0]   err_count;
    logic [7:0]   word_count;

    int checks = 0;
    int errors = 0;

    // Model: characters received so far, last delivered word and counters.
    bit           m_bits[$];
    logic [W-1:0] m_raw;
    logic [W-1:0] m_out;
    logic         m_valid;
    logic         m_err;
    int           m_errcnt;
    int           m_wc;

    bit_reverse_rx #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
        .char_ready(char_ready), .addr(addr), .word_out(word_out), .word_raw(word_raw),
        .word_valid(word_valid), .word_ready(word_ready), .err(err),
        .err_count(err_count), .word_count(word_count)
    );

    always #5 clk = ~clk;

    wire [38:0] act_vec = {char_ready, addr, word_out, word_raw, word_valid, err, err_count, word_count};
    localparam logic [38:0] RESET_VEC = {1'b1, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};

    function automatic logic [38:0] exp_vec();
        return {~m_valid, 4'(m_bits.size()), m_out, m_raw, m_valid, m_err, 8'(m_errcnt), 8'(m_wc)};
    endfunction

    function automatic logic [7:0] ch(input int b);
        return (b != 0) ? 8'h31 : 8'h30;
    endfunction

    function automatic logic [7:0] bad_char();
        logic [7:0] c;
        c = 8'($urandom_range(0, 255));
        while (c == 8'h30 || c == 8'h31) c = 8'($urandom_range(0, 255));
        return c;
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_raw = '0;
        m_out = '0;
        m_valid = 1'b0;
        m_err = 1'b0;
        m_errcnt = 0;
        m_wc = 0;
    endtask

    // One clock: inputs change on the falling edge, outputs settle 1 ns after the rising edge.
    task automatic cycle(input logic v, input logic [7:0] c, input logic r, input logic rst_n = 1'b1);
        int raw;
        int rev;
        @(negedge clk);
        reset = rst_n;
        char_valid = v;
        char_in = c;
        word_ready = r;
        @(posedge clk);
        m_err = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (!m_valid) begin
            if (v) begin
                if (c == 8'h30 || c == 8'h31) begin
                    m_bits.push_back(c[0]);
                    if (m_bits.size() == W) begin
                        raw = 0;
                        rev = 0;
                        for (int i = 0; i < W; i++) begin
                            raw += int'(m_bits[i]) * (1 << i);
                            rev += int'(m_bits[i]) * (1 << (W - 1 - i));
                        end
                        m_raw = W'(raw);
                        m_out = W'(rev);
                        m_valid = 1'b1;
                        m_bits.delete();
                    end
                end else begin
                    m_err = 1'b1;
                    m_bits.delete();
                    if (m_errcnt < 255) m_errcnt++;
                end
            end
        end else if (r) begin
            m_valid = 1'b0;
            m_wc = (m_wc + 1) % 256;
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 8'h31, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (act_vec !== RESET_VEC) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected %h", act_vec, RESET_VEC);
        end
        cycle(1'b0, 8'h00, 1'b0);
        checks++;
        if (char_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_char_ready: got %b expected 1", char_ready);
        end
    endtask

    task automatic test_basic();
        int p[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        for (int k = 0; k < 8; k++) cycle(1'b1, ch(p[k]), 1'b1);
        checks++;
        if ({word_valid, word_raw, word_out} !== {1'b1, 8'h0F, 8'hF0}) begin
            errors++;
            $display("[TB] FAIL basic_word: got v=%b raw=%h out=%h expected v=1 raw=0f out=f0",
                     word_valid, word_raw, word_out);
        end
        cycle(1'b1, 8'h31, 1'b1);
        checks++;
        if ({word_valid, word_count, addr, char_ready} !== {1'b0, 8'd1, 4'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL basic_deliver: got v=%b wc=%0d addr=%0d rdy=%b expected v=0 wc=1 addr=0 rdy=1",
                     word_valid, word_count, addr, char_ready);
        end
    endtask

    task automatic test_patterns();
        for (int k = 0; k < 8; k++) cycle(1'b1, ch(k == 0), 1'b1);
        checks++;
        if ({word_raw, word_out} !== {8'h01, 8'h80}) begin
            errors++;
            $display("[TB] FAIL pattern_lsb: got raw=%h out=%h expected raw=01 out=80", word_raw, word_out);
        end
        cycle(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 8; k++) cycle(1'b1, ch(k == 7), 1'b1);
        checks++;
        if ({word_raw, word_out} !== {8'h80, 8'h01}) begin
            errors++;
            $display("[TB] FAIL pattern_msb: got raw=%h out=%h expected raw=80 out=01", word_raw, word_out);
        end
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if (act_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL pattern_model: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] held_out;
        logic [W-1:0] held_raw;
        logic [7:0]   wc_before;
        wc_before = word_count;
        for (int k = 0; k < 8; k++) cycle(1'b1, ch($urandom_range(0, 1)), 1'b0);
        held_out = m_out;
        held_raw = m_raw;
        for (int i = 0; i < 5; i++) begin
            cycle(i[0] == 1'b0, ch($urandom_range(0, 1)), 1'b0);
            checks++;
            if ({word_valid, char_ready, addr, word_out, word_raw} !== {1'b1, 1'b0, 4'd0, held_out, held_raw}) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: got v=%b rdy=%b addr=%0d out=%h raw=%h expected v=1 rdy=0 addr=0 out=%h raw=%h",
                         i, word_valid, char_ready, addr, word_out, word_raw, held_out, held_raw);
            end
        end
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if ({word_valid, char_ready, word_count} !== {1'b0, 1'b1, 8'(wc_before + 1)}) begin
            errors++;
            $display("[TB] FAIL hold_release: got v=%b rdy=%b wc=%0d expected v=0 rdy=1 wc=%0d",
                     word_valid, char_ready, word_count, wc_before + 1);
        end
    endtask

    task automatic test_error();
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'h31, 1'b0);
        cycle(1'b1, 8'h31, 1'b0);
        cycle(1'b1, 8'h58, 1'b0);
        checks++;
        if ({err, addr, err_count, word_valid} !== {1'b1, 4'd0, 8'd1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL error_pulse: got err=%b addr=%0d ec=%0d v=%b expected err=1 addr=0 ec=1 v=0",
                     err, addr, err_count, word_valid);
        end
        cycle(1'b0, 8'h00, 1'b0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL error_one_cycle: got %b expected 0", err);
        end
        for (int k = 0; k < 8; k++) cycle(1'b1, ch($urandom_range(0, 1)), 1'b0);
        checks++;
        if (act_vec !== exp_vec() || word_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL error_recover_word: got %h expected %h", act_vec, exp_vec());
        end
        cycle(1'b0, 8'h00, 1'b1);
        // Illegal character in the last slot must not complete a word.
        for (int k = 0; k < 7; k++) cycle(1'b1, 8'h30, 1'b1);
        cycle(1'b1, 8'h32, 1'b1);
        checks++;
        if ({word_valid, err, addr, err_count} !== {1'b0, 1'b1, 4'd0, 8'd2}) begin
            errors++;
            $display("[TB] FAIL error_last_slot: got v=%b err=%b addr=%0d ec=%0d expected v=0 err=1 addr=0 ec=2",
                     word_valid, err, addr, err_count);
        end
        for (int k = 0; k < 300; k++) cycle(1'b1, bad_char(), 1'b1);
        checks++;
        if ({err_count, err} !== {8'd255, 1'b1}) begin
            errors++;
            $display("[TB] FAIL error_saturate: got ec=%0d err=%b expected ec=255 err=1", err_count, err);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) cycle(1'b1, ch($urandom_range(0, 1)), 1'b1);
        cycle(1'b1, 8'h31, 1'b1, 1'b0);
        checks++;
        if (act_vec !== RESET_VEC) begin
            errors++;
            $display("[TB] FAIL reset_partial: got %h expected %h", act_vec, RESET_VEC);
        end
        for (int k = 0; k < 8; k++) cycle(1'b1, ch($urandom_range(0, 1)), 1'b0);
        checks++;
        if (act_vec !== exp_vec() || word_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_clean_word: got %h expected %h", act_vec, exp_vec());
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (act_vec !== RESET_VEC) begin
            errors++;
            $display("[TB] FAIL reset_pending: got %h expected %h", act_vec, RESET_VEC);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        for (int w = 0; w < 256; w++) begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (addr !== 4'(k)) begin
                    errors++;
                    $display("[TB] FAIL wrap_addr w%0d: got %0d expected %0d", w, addr, k);
                end
                cycle(1'b1, ch($urandom_range(0, 1)), 1'b1);
            end
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL wrap_word w%0d: got %h expected %h", w, act_vec, exp_vec());
            end
            cycle(1'b0, 8'h00, 1'b1);
        end
        checks++;
        if ({word_count, addr} !== {8'd0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL wrap_count: got wc=%0d addr=%0d expected wc=0 addr=0", word_count, addr);
        end
    endtask

    task automatic test_random();
        logic       v;
        logic [7:0] c;
        logic       r;
        logic       rn;
        for (int i = 0; i < 3000; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 7) == 0) ? bad_char() : ch($urandom_range(0, 1));
            r  = ($urandom_range(0, 2) == 0);
            rn = ($urandom_range(0, 199) != 0);
            cycle(v, c, r, rn);
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL random_cycle%0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_patterns();
        test_hold();
        test_error();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
